booth_mul_share_arbiter: RTL and testbench
==========================================

// Module: booth_mul_share_arbiter
// PURPOSE
//  Shares one pipelined 16x16 radix-4 Booth multiplier among N_REQ requesters.
//  - Round-robin arbitration; at most one operand pair issued per cycle.
//  - Tracks in-flight tags alongside the multiplier pipeline.
//  - Returns each product with the ID of the requester that issued it.
//  - Sits between the requester clients and the multiplier top; the multiplier pipeline never stalls.
// PARAMETERS
//  N_REQ    4   number of requesters, 2..8
//  ID_W     2   requester ID width, $clog2(N_REQ)
//  MUL_LAT  2   cycles from mul_a/mul_b to a valid mul_product; must match the multiplier
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            asynchronous, active-high reset
//  enable       in   1            1 = new grants allowed; 0 = drain in-flight work only
//  req_valid    in   N_REQ        per-requester request
//  req_a        in   16*N_REQ     operand A, slice i belongs to requester i
//  req_b        in   16*N_REQ     operand B, slice i belongs to requester i
//  req_ready    out  N_REQ        one-hot grant; handshake for requester i = req_valid[i] & req_ready[i]
//  mul_a        out  16           operand A to the multiplier
//  mul_b        out  16           operand B to the multiplier
//  mul_product  in   32           product returned by the multiplier
//  rsp_valid    out  1            response strobe, 1 cycle, no backpressure
//  rsp_id       out  ID_W         requester ID of the response
//  rsp_product  out  32           product for that response
//  idle         out  1            1 = no request granted this cycle and no tag in flight
// BEHAVIOUR
//  Reset (async assert, sync deassert):
//   - RR pointer = 0; all tag stages invalid.
//   - rsp_valid = 0, rsp_id = 0, idle = 1.
//   - req_ready = 0 while rst is high.
//  Arbitration (combinational):
//   - Search starts at ptr and proceeds ptr, ptr+1, ... mod N_REQ; the first asserted req_valid wins.
//   - Grant only when enable = 1; req_ready is one-hot or zero.
//   - mul_a/mul_b = the winner's operands; 16'h0 when there is no grant.
//   - On a grant, ptr <= (winner+1) mod N_REQ. With no grant, ptr holds.
//   - A requester keeps req_valid and its operands stable until it sees req_ready.
//   - An N_REQ-1 wrap to 0 is required.
//  Tag pipe:
//   - MUL_LAT-deep shift register of {valid, id}; stage0 <= {grant_any, winner_id}.
//   - rsp_valid and rsp_id come from the last stage; rsp_product = mul_product, unregistered.
//   - Issue-to-response latency is exactly MUL_LAT cycles; back-to-back issues give back-to-back responses.
//   - rsp_id holds its last value when rsp_valid = 0.
//  enable deasserted mid-stream:
//   - No new grants.
//   - In-flight tags still complete.
//   - idle rises the cycle after the last tag leaves the pipe.
//  Reset mid-operation:
//   - In-flight tags are discarded; no rsp_valid is produced for them.
//   - Requesters re-request after reset.
//  Simultaneous requests from all requesters: each is served once every N_REQ cycles (fairness bound).
// CONFIGURATION
//  BOOTH_ARB_PERF_EN defined:
//   - Adds outputs perf_issue_cnt[31:0] (total grants) and perf_busy_cnt[31:0] (cycles with idle = 0).
//   - Both counters wrap at 2^32, reset to 0, and clear on perf_clr (input, 1 bit, synchronous).
//   - If perf_clr and an increment coincide, the counter result is 0.
//  BOOTH_ARB_PERF_EN undefined: these ports and counters do not exist; the behaviour above is unchanged.
// STRUCTURE
//  booth_mul_arb_pkg:
//   - OPW = 16, PRODW = 32.
//   - Typedef tag_t = {valid, id}.
//   - Function rr_next(ptr, N_REQ).
//  Sub-module rr_arbiter_onehot (N_REQ param): inputs req, ptr, en; outputs gnt one-hot and gnt_id.
//  Top holds the pointer register, the operand mux, the tag pipe and the optional perf counters.
// TESTING
//  1. Reset, then req0 with a=16'h0003, b=16'hFFFE:
//     req_ready[0] in the same cycle; MUL_LAT cycles later rsp_valid=1, rsp_id=0, rsp_product=32'hFFFFFFFA.
//  2. All four requesters held valid for 8 cycles:
//     grants 0,1,2,3,0,1,2,3; responses return in the same order at MUL_LAT spacing with no gaps.
//  3. ptr=3 with req_valid=4'b1001: req3 is granted, then req0. Confirms the wrap.
//  4. enable dropped with 2 tags in flight: no new req_ready; 2 responses arrive; idle=1 after the last one.
//  5. rst pulsed with tags in flight: rsp_valid=0 immediately, no stale responses after release, ptr=0.
//  6. BOOTH_ARB_PERF_EN defined, 5 grants then perf_clr: perf_issue_cnt reads 5 and then 0.

Source files
------------

// File: rtl/booth_mul_arb_pkg.sv
// Shared types and helpers for the Booth multiplier sharing arbiter.
// Holds operand/product widths, the in-flight tag layout and the round-robin step.
package booth_mul_arb_pkg;

    localparam int OPW      = 16;
    localparam int PRODW    = 32;
    // Wide enough for the largest supported requester count (8)
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int rr_next(input int ptr, input int n_req);
        return (ptr + 1 >= n_req) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
// Produces a one-hot (or all-zero) grant plus the binary index of the winner.
module rr_arbiter_onehot #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id
);

    localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);

    logic [ID_W:0] idx;
    logic          found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= N_REQ_W) begin
                idx = idx - N_REQ_W;
            end
            if (en && !found && req[idx[ID_W-1:0]]) begin
                gnt[idx[ID_W-1:0]] = 1'b1;
                gnt_id             = idx[ID_W-1:0];
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mul_share_arbiter.sv
// Shares one pipelined 16x16 Booth multiplier among N_REQ requesters, tagging results with IDs.
// Optional performance counters are built when BOOTH_ARB_PERF_EN is defined.
module booth_mul_share_arbiter
    import booth_mul_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [OPW*N_REQ-1:0]   req_a,
    input  logic [OPW*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [OPW-1:0]         mul_a,
    output logic [OPW-1:0]         mul_b,
    input  logic [PRODW-1:0]       mul_product,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [PRODW-1:0]       rsp_product,
`ifdef BOOTH_ARB_PERF_EN
    input  logic                   perf_clr,
    output logic [31:0]            perf_issue_cnt,
    output logic [31:0]            perf_busy_cnt,
`endif
    output logic                   idle
);

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  ptr_reg;
    logic             grant_any;
    logic             in_flight;
    tag_t             tag_pipe [MUL_LAT];
    logic [OPW-1:0]   a_masked [N_REQ];
    logic [OPW-1:0]   b_masked [N_REQ];

    // Grants are suppressed while reset is held so no handshake can slip through
    rr_arbiter_onehot #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_reg),
        .en     (enable & ~rst),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign grant_any = |gnt;
    assign req_ready = gnt;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_opmask
            assign a_masked[gi] = gnt[gi] ? req_a[gi*OPW +: OPW] : '0;
            assign b_masked[gi] = gnt[gi] ? req_b[gi*OPW +: OPW] : '0;
        end
    endgenerate

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            mul_a = mul_a | a_masked[i];
            mul_b = mul_b | b_masked[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (grant_any) begin
            ptr_reg <= ID_W'(rr_next(int'(gnt_id), N_REQ));
        end
    end

    // Valid bits always shift; IDs only advance behind a valid tag so rsp_id holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            tag_pipe[0].valid <= grant_any;
            if (grant_any) begin
                tag_pipe[0].id <= TAG_ID_W'(gnt_id);
            end
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_pipe[s].valid <= tag_pipe[s-1].valid;
                if (tag_pipe[s-1].valid) begin
                    tag_pipe[s].id <= tag_pipe[s-1].id;
                end
            end
        end
    end

    always_comb begin
        in_flight = 1'b0;
        for (int s = 0; s < MUL_LAT; s++) begin
            in_flight = in_flight | tag_pipe[s].valid;
        end
    end

    assign rsp_valid   = tag_pipe[MUL_LAT-1].valid;
    assign rsp_id      = ID_W'(tag_pipe[MUL_LAT-1].id);
    assign rsp_product = mul_product;
    assign idle        = ~grant_any & ~in_flight;

`ifdef BOOTH_ARB_PERF_EN
    // A clear in the same cycle as an increment leaves the counter at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_busy_cnt  <= '0;
        end else if (perf_clr) begin
            perf_issue_cnt <= '0;
            perf_busy_cnt  <= '0;
        end else begin
            if (grant_any) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (!idle) begin
                perf_busy_cnt <= perf_busy_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_booth_mul_share_arbiter.sv
// Directed bench for booth_mul_share_arbiter with a 2-stage multiplier model and response scoreboard.
// Perf counter checks are built when BOOTH_ARB_PERF_EN is defined.
module tb_booth_mul_share_arbiter;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 enable = 1'b1;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [16*N_REQ-1:0]  req_a = '0;
    logic [16*N_REQ-1:0]  req_b = '0;
    logic [N_REQ-1:0]     req_ready;
    logic [15:0]          mul_a;
    logic [15:0]          mul_b;
    logic [31:0]          mul_product;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [31:0]          rsp_product;
    logic                 idle;
`ifdef BOOTH_ARB_PERF_EN
    logic                 perf_clr = 1'b0;
    logic [31:0]          perf_issue_cnt;
    logic [31:0]          perf_busy_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    logic [ID_W-1:0] last_id = '0;

    typedef struct {
        int          due;
        logic [1:0]  id;
        logic [31:0] prod;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] m1 = '0;
    logic [31:0] m2 = '0;

    booth_mul_share_arbiter #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
`ifdef BOOTH_ARB_PERF_EN
        .perf_clr       (perf_clr),
        .perf_issue_cnt (perf_issue_cnt),
        .perf_busy_cnt  (perf_busy_cnt),
`endif
        .idle        (idle)
    );

    always #5 clk = ~clk;

    // Two-stage signed multiplier standing in for the Booth core
    always @(posedge clk) begin
        m1    <= 32'($signed(mul_a)) * 32'($signed(mul_b));
        m2    <= m1;
        cyc_n <= cyc_n + 1;
    end
    assign mul_product = m2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [1:0] id, input logic [31:0] prod);
        exp_t e;
        e.due  = cyc_n + MUL_LAT;
        e.id   = id;
        e.prod = prod;
        exp_q.push_back(e);
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    // Response scoreboard: exact-cycle arrival, ID and product; silence and ID hold otherwise
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc_n) begin
                chk("rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                chk("rsp_product", rsp_product, exp_q[0].prod);
                $display("rsp cyc=%0d id=%0d product=%h", cyc_n, rsp_id, rsp_product);
                last_id = exp_q[0].id;
                void'(exp_q.pop_front());
            end else begin
                chk("rsp_quiet", 32'(rsp_valid), 32'd0);
                chk("rsp_id_hold", 32'(rsp_id), 32'(last_id));
            end
        end
    end

    logic [31:0] t2_prod [4];
    logic [15:0] t2_a    [4];

    initial begin
        t2_prod[0] = 32'h0000_0002; t2_a[0] = 16'h0001;
        t2_prod[1] = 32'h0000_000C; t2_a[1] = 16'h0003;
        t2_prod[2] = 32'hFFFF_FFFB; t2_a[2] = 16'hFFFF;
        t2_prod[3] = 32'h0000_2710; t2_a[3] = 16'd100;

        // Reset state: a pending request must not be granted while rst is high
        req_valid = 4'b0001;
        cyc(); cyc();
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        rst = 1'b0;

        // 1: single request, 3 * -2
        cyc();
        set_op(0, 16'h0003, 16'hFFFE);
        req_valid = 4'b0001;
        expect_rsp(2'd0, 32'hFFFF_FFFA);
        #1;
        $display("issue t1 ready=%b mul_a=%h mul_b=%h", req_ready, mul_a, mul_b);
        chk("t1_ready", 32'(req_ready), 32'b0001);
        chk("t1_mul_a", 32'(mul_a), 32'h0003);
        chk("t1_mul_b", 32'(mul_b), 32'hFFFE);
        chk("t1_idle", 32'(idle), 32'd0);
        cyc();
        req_valid = '0;
        #1;
        chk("t1_nogrant", 32'(req_ready), 32'd0);
        chk("t1_mul_a_zero", 32'(mul_a), 32'd0);
        cyc(); cyc(); cyc();
        chk("t1_drained_idle", 32'(idle), 32'd1);

        // 3: move ptr to 3, then 1001 grants req3 then req0
        cyc();
        set_op(2, 16'h0010, 16'h0010);
        req_valid = 4'b0100;
        expect_rsp(2'd2, 32'h0000_0100);
        #1;
        chk("t3_pre", 32'(req_ready), 32'b0100);
        cyc();
        set_op(3, 16'd7, 16'd9);
        set_op(0, 16'hFFFF, 16'hFFFF);
        req_valid = 4'b1001;
        expect_rsp(2'd3, 32'h0000_003F);
        #1;
        $display("issue t3 ready=%b", req_ready);
        chk("t3_wrap_r3", 32'(req_ready), 32'b1000);
        cyc();
        req_valid = 4'b0001;
        expect_rsp(2'd0, 32'h0000_0001);
        #1;
        $display("issue t3 ready=%b", req_ready);
        chk("t3_wrap_r0", 32'(req_ready), 32'b0001);
        cyc();
        set_op(3, 16'h8000, 16'h0002);
        req_valid = 4'b1000;
        expect_rsp(2'd3, 32'hFFFF_0000);
        #1;
        chk("t3_r3_again", 32'(req_ready), 32'b1000);

        // 2: all four requesters for 8 cycles, ptr now 0
        cyc();
        set_op(0, 16'h0001, 16'h0002);
        set_op(1, 16'h0003, 16'h0004);
        set_op(2, 16'hFFFF, 16'h0005);
        set_op(3, 16'd100, 16'd100);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) cyc();
            expect_rsp(2'(c % 4), t2_prod[c % 4]);
            #1;
            $display("issue t2 c=%0d ready=%b mul_a=%h", c, req_ready, mul_a);
            chk("t2_ready", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            chk("t2_mul_a", 32'(mul_a), 32'(t2_a[c % 4]));
        end
        cyc();
        req_valid = '0;
        cyc(); cyc(); cyc();

        // 4: enable drops with two tags in flight
        cyc();
        set_op(0, 16'd2, 16'd3);
        set_op(1, 16'hFFFD, 16'd4);
        req_valid = 4'b0011;
        expect_rsp(2'd0, 32'h0000_0006);
        #1;
        chk("t4_g0", 32'(req_ready), 32'b0001);
        cyc();
        expect_rsp(2'd1, 32'hFFFF_FFF4);
        #1;
        chk("t4_g1", 32'(req_ready), 32'b0010);
        cyc();
        enable = 1'b0;
        #1;
        chk("t4_en_off_ready", 32'(req_ready), 32'd0);
        chk("t4_busy_a", 32'(idle), 32'd0);
        cyc();
        #1;
        chk("t4_en_off_ready2", 32'(req_ready), 32'd0);
        chk("t4_busy_b", 32'(idle), 32'd0);
        cyc();
        #1;
        chk("t4_idle", 32'(idle), 32'd1);
        chk("t4_en_off_ready3", 32'(req_ready), 32'd0);
        req_valid = '0;
        enable = 1'b1;

        // 5: reset with tags in flight (ptr is 2 before reset)
        cyc();
        set_op(2, 16'd5, 16'd5);
        req_valid = 4'b0100;
        #1;
        chk("t5_g2", 32'(req_ready), 32'b0100);
        cyc();
        req_valid = 4'b1000;
        #1;
        chk("t5_g3", 32'(req_ready), 32'b1000);
        cyc();
        chk("t5_pre_rsp", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        last_id = '0;
        req_valid = '0;
        #1;
        chk("t5_rst_rsp", 32'(rsp_valid), 32'd0);
        chk("t5_rst_idle", 32'(idle), 32'd1);
        cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        set_op(0, 16'h0001, 16'h0002);
        req_valid = 4'b1111;
        expect_rsp(2'd0, 32'h0000_0002);
        #1;
        chk("t5_ptr0", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        cyc(); cyc(); cyc();

`ifdef BOOTH_ARB_PERF_EN
        // 6: perf counters
        cyc();
        perf_clr = 1'b1;
        cyc();
        perf_clr = 1'b0;
        set_op(0, 16'd3, 16'd3);
        req_valid = 4'b0001;
        #1;
        chk("t6_issue_clr", perf_issue_cnt, 32'd0);
        chk("t6_busy_clr", perf_busy_cnt, 32'd0);
        for (int g = 0; g < 5; g++) begin
            if (g > 0) cyc();
            expect_rsp(2'd0, 32'd9);
        end
        cyc();
        req_valid = '0;
        #1;
        chk("t6_issue5", perf_issue_cnt, 32'd5);
        cyc(); cyc();
        chk("t6_busy7", perf_busy_cnt, 32'd7);
        perf_clr = 1'b1;
        req_valid = 4'b0001;
        expect_rsp(2'd0, 32'd9);
        cyc();
        perf_clr = 1'b0;
        req_valid = '0;
        #1;
        chk("t6_clr_wins", perf_issue_cnt, 32'd0);
        cyc(); cyc(); cyc();
`endif

        chk("exp_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
